// File: rtl/ctrl_pkg.sv
// Shared types for the RV32I pipelined control path: opcodes, control enums and
// per-stage control bundles.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                            IMM_J = 3'b011, IMM_U = 3'b100} imm_src_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FN = 2'b10,
                            ALU_IMM = 2'b11} alu_op_e;
  typedef enum logic [1:0] {JMP_NONE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10} jump_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    result_src_e result_src;
  } ctrl_wb_t;

  typedef struct packed {
    logic       valid;
    logic       mem_write;
    logic       mem_read;
    logic [2:0] funct3;
    ctrl_wb_t   wb;
  } ctrl_mem_t;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    alu_op_e    alu_op;
    logic       branch;
    jump_e      jump;
    logic       a_pc;
    logic [2:0] funct3;
    ctrl_mem_t  mem;
  } ctrl_ex_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: builds the full downstream control bundle and
// flags opcodes outside RV32I base.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       valid,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  output imm_src_e   imm_src,
  output ctrl_ex_t   ctrl,
  output logic       illegal
);

  logic known;

  always_comb begin
    imm_src = IMM_I;
    ctrl    = '0;
    known   = 1'b1;
    case (op)
      OP_LOAD: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem.mem_read = 1'b1;
        ctrl.mem.wb.reg_write = 1'b1;
        ctrl.mem.wb.result_src = RES_MEM;
      end
      OP_STORE: begin
        imm_src = IMM_S;
        ctrl.alu_src = 1'b1;
        ctrl.mem.mem_write = 1'b1;
      end
      OP_OPIMM: begin
        ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALU_FN;
        ctrl.mem.wb.reg_write = 1'b1;
      end
      OP_OP: begin
        ctrl.alu_op = ALU_FN;
        ctrl.mem.wb.reg_write = 1'b1;
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        ctrl.alu_op = ALU_BR;
        ctrl.branch = 1'b1;
      end
      OP_JAL: begin
        imm_src = IMM_J;
        ctrl.alu_src = 1'b1;
        ctrl.jump = JMP_JAL;
        ctrl.mem.wb.reg_write = 1'b1;
        ctrl.mem.wb.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl.alu_src = 1'b1;
        ctrl.jump = JMP_JALR;
        ctrl.mem.wb.reg_write = 1'b1;
        ctrl.mem.wb.result_src = RES_PC4;
      end
      OP_LUI: begin
        imm_src = IMM_U;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALU_IMM;
        ctrl.mem.wb.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm_src = IMM_U;
        ctrl.alu_src = 1'b1;
        ctrl.a_pc = 1'b1;
        ctrl.mem.wb.reg_write = 1'b1;
      end
      default: known = 1'b0;
    endcase

    // Empty slots and unknown opcodes both travel as all-zero bubbles.
    if (!valid || !known) begin
      imm_src = IMM_I;
      ctrl    = '0;
    end else begin
      ctrl.valid        = 1'b1;
      ctrl.mem.valid    = 1'b1;
      ctrl.mem.wb.valid = 1'b1;
      ctrl.funct3       = funct3;
      ctrl.mem.funct3   = funct3;
    end
    illegal = valid & ~known;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// RV32I control pipeline ID/EX -> MEM[MEM_STAGES] -> WB with bubble/freeze and a
// retire counter. Define CTRL_ILLEGAL_TRAP_EN for a sticky illegal-opcode flag.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [6:0]       id_op_i,
  input  logic [2:0]       id_funct3_i,
  input  logic             bubble_i,
  input  logic             freeze_i,
  output logic [2:0]       id_imm_src_o,
  output logic             ex_valid_o,
  output logic             ex_alu_src_o,
  output logic [1:0]       ex_alu_op_o,
  output logic             ex_branch_o,
  output logic [1:0]       ex_jump_o,
  output logic             ex_a_pc_o,
  output logic [2:0]       ex_funct3_o,
  output logic             mem_valid_o,
  output logic             mem_write_o,
  output logic             mem_read_o,
  output logic [2:0]       mem_funct3_o,
  output logic             wb_valid_o,
  output logic             wb_reg_write_o,
  output logic [1:0]       wb_result_src_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_count_o,
  output logic             illegal_o
);

  imm_src_e         imm_src;
  ctrl_ex_t         dec, ex_q;
  ctrl_mem_t        mem_last;
  ctrl_wb_t         wb_q;
  logic             dec_illegal;
  logic             retire;
  logic [CNT_W-1:0] cnt;

  ctrl_decode u_dec (
    .valid   (id_valid_i),
    .op      (id_op_i),
    .funct3  (id_funct3_i),
    .imm_src (imm_src),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)         ex_q <= '0;
    else if (!freeze_i) ex_q <= bubble_i ? '0 : dec;
  end

  for (genvar i = 0; i < MEM_STAGES; i++) begin : g_mem
    ctrl_mem_t d, q;
    if (i == 0) begin : g_first
      assign d = ex_q.mem;
    end else begin : g_next
      assign d = g_mem[i-1].q;
    end
    always_ff @(posedge clk) begin
      if (!rst_n)         q <= '0;
      else if (!freeze_i) q <= d;
    end
  end
  assign mem_last = g_mem[MEM_STAGES-1].q;

  always_ff @(posedge clk) begin
    if (!rst_n)         wb_q <= '0;
    else if (!freeze_i) wb_q <= mem_last.wb;
  end

  assign retire = wb_q.valid & ~freeze_i;

  always_ff @(posedge clk) begin
    if (!rst_n)      cnt <= '0;
    else if (retire) cnt <= cnt + CNT_W'(1);
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                       illegal_q <= 1'b0;
    else if (!freeze_i && !bubble_i && dec_illegal)   illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
  assign illegal_o      = 1'b0;
`endif

  assign id_imm_src_o    = imm_src;
  assign ex_valid_o      = ex_q.valid;
  assign ex_alu_src_o    = ex_q.alu_src;
  assign ex_alu_op_o     = ex_q.alu_op;
  assign ex_branch_o     = ex_q.branch & ex_q.valid;
  assign ex_jump_o       = ex_q.valid ? ex_q.jump : 2'b00;
  assign ex_a_pc_o       = ex_q.a_pc;
  assign ex_funct3_o     = ex_q.funct3;
  assign mem_valid_o     = mem_last.valid;
  assign mem_write_o     = mem_last.mem_write & mem_last.valid;
  assign mem_read_o      = mem_last.mem_read & mem_last.valid;
  assign mem_funct3_o    = mem_last.funct3;
  assign wb_valid_o      = wb_q.valid;
  assign wb_reg_write_o  = wb_q.reg_write & wb_q.valid;
  assign wb_result_src_o = wb_q.result_src;
  assign retire_o        = retire;
  assign retire_count_o  = cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode table plus reset, latency, bubble/freeze,
// counter-wrap and illegal-opcode sequences on two configurations.
module tb_ctrl_pipe;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid, bubble, freeze;
  logic [6:0] id_op;
  logic [2:0] id_funct3;

  // dut: MEM_STAGES=1, CNT_W=32
  logic [2:0] imm, ex_f3, mem_f3;
  logic ex_v, ex_as, ex_br, ex_apc, mem_v, mem_w, mem_r, wb_v, wb_rw, ret, ill;
  logic [1:0] ex_aop, ex_j, wb_rs;
  logic [31:0] cnt;
  // dut3: MEM_STAGES=3, CNT_W=8
  logic [2:0] x_imm, x_ex_f3, x_mem_f3;
  logic x_ex_v, x_ex_as, x_ex_br, x_ex_apc, x_mem_v, x_mem_w, x_mem_r, x_wb_v, x_wb_rw, x_ret, x_ill;
  logic [1:0] x_ex_aop, x_ex_j, x_wb_rs;
  logic [7:0] x_cnt;

  ctrl_pipe #(.MEM_STAGES(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_op_i(id_op),
    .id_funct3_i(id_funct3), .bubble_i(bubble), .freeze_i(freeze),
    .id_imm_src_o(imm), .ex_valid_o(ex_v), .ex_alu_src_o(ex_as), .ex_alu_op_o(ex_aop),
    .ex_branch_o(ex_br), .ex_jump_o(ex_j), .ex_a_pc_o(ex_apc), .ex_funct3_o(ex_f3),
    .mem_valid_o(mem_v), .mem_write_o(mem_w), .mem_read_o(mem_r), .mem_funct3_o(mem_f3),
    .wb_valid_o(wb_v), .wb_reg_write_o(wb_rw), .wb_result_src_o(wb_rs),
    .retire_o(ret), .retire_count_o(cnt), .illegal_o(ill));

  ctrl_pipe #(.MEM_STAGES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_op_i(id_op),
    .id_funct3_i(id_funct3), .bubble_i(bubble), .freeze_i(freeze),
    .id_imm_src_o(x_imm), .ex_valid_o(x_ex_v), .ex_alu_src_o(x_ex_as), .ex_alu_op_o(x_ex_aop),
    .ex_branch_o(x_ex_br), .ex_jump_o(x_ex_j), .ex_a_pc_o(x_ex_apc), .ex_funct3_o(x_ex_f3),
    .mem_valid_o(x_mem_v), .mem_write_o(x_mem_w), .mem_read_o(x_mem_r), .mem_funct3_o(x_mem_f3),
    .wb_valid_o(x_wb_v), .wb_reg_write_o(x_wb_rw), .wb_result_src_o(x_wb_rs),
    .retire_o(x_ret), .retire_count_o(x_cnt), .illegal_o(x_ill));

  typedef struct {
    logic [6:0] op;  logic [2:0] f3;  logic [2:0] imm;
    logic v; logic asrc; logic [1:0] aop; logic br; logic [1:0] jmp; logic apc;
    logic mw; logic mr; logic rw; logic [1:0] rs;
  } vec_t;

  localparam int N = 10;
  vec_t tbl [N];
  int pass_cnt = 0, tot_cnt = 0;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] im,
      input logic v, input logic asrc, input logic [1:0] aop, input logic br, input logic [1:0] jmp,
      input logic apc, input logic mw, input logic mr, input logic rw, input logic [1:0] rs);
    vec_t e;
    e.op = op; e.f3 = f3; e.imm = im; e.v = v; e.asrc = asrc; e.aop = aop; e.br = br;
    e.jmp = jmp; e.apc = apc; e.mw = mw; e.mr = mr; e.rw = rw; e.rs = rs;
    return e;
  endfunction

  function automatic vec_t getv(input int i);
    if (i >= 0 && i < N) return tbl[i];
    return mk(7'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    id_valid = 1'b0; id_op = 7'd0; id_funct3 = 3'd0; bubble = 1'b0; freeze = 1'b0;
  endtask

  task automatic do_reset;
    idle(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
  endtask

  initial begin
    vec_t e;
    tbl[0] = mk(7'b0000011, 3'd2, 3'b000, 1, 1, 2'b00, 0, 2'b00, 0, 0, 1, 1, 2'b01);
    tbl[1] = mk(7'b0100011, 3'd1, 3'b001, 1, 1, 2'b00, 0, 2'b00, 0, 1, 0, 0, 2'b00);
    tbl[2] = mk(7'b0010011, 3'd7, 3'b000, 1, 1, 2'b10, 0, 2'b00, 0, 0, 0, 1, 2'b00);
    tbl[3] = mk(7'b0110011, 3'd5, 3'b000, 1, 0, 2'b10, 0, 2'b00, 0, 0, 0, 1, 2'b00);
    tbl[4] = mk(7'b1100011, 3'd6, 3'b010, 1, 0, 2'b01, 1, 2'b00, 0, 0, 0, 0, 2'b00);
    tbl[5] = mk(7'b1101111, 3'd3, 3'b011, 1, 1, 2'b00, 0, 2'b01, 0, 0, 0, 1, 2'b10);
    tbl[6] = mk(7'b1100111, 3'd0, 3'b000, 1, 1, 2'b00, 0, 2'b10, 0, 0, 0, 1, 2'b10);
    tbl[7] = mk(7'b0110111, 3'd4, 3'b100, 1, 1, 2'b11, 0, 2'b00, 0, 0, 0, 1, 2'b00);
    tbl[8] = mk(7'b0010111, 3'd1, 3'b100, 1, 1, 2'b00, 0, 2'b00, 1, 0, 0, 1, 2'b00);
    tbl[9] = mk(7'b0000000, 3'd3, 3'b000, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 2'b00);

    // Reset with random inputs, then first-instruction latency
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      id_valid = 1'($urandom); id_op = 7'($urandom); id_funct3 = 3'($urandom);
      bubble = 1'($urandom); freeze = 1'($urandom);
      step();
    end
    chk("reset_outputs", {ex_v, ex_as, ex_aop, ex_br, ex_j, ex_apc, ex_f3, mem_v, mem_w, mem_r,
        mem_f3, wb_v, wb_rw, wb_rs, ret, ill}, 64'd0);
    chk("reset_count", cnt, 64'd0);
    chk("reset_count3", {x_cnt, x_wb_v, x_mem_v, x_ex_v}, 64'd0);
    idle(); rst_n = 1'b1;
    id_valid = 1'b1; id_op = 7'b0110011;
    step();
    chk("first_ex_valid", ex_v, 64'd1);

    // Decode table, back to back, MEM_STAGES=1
    do_reset();
    for (int k = 0; k < N + 2; k++) begin
      if (k < N) begin
        e = tbl[k];
        id_valid = 1'b1; id_op = e.op; id_funct3 = e.f3;
        #1 chk($sformatf("imm_src[%0d]", k), imm, e.imm);
      end else idle();
      step();
      e = getv(k);
      chk($sformatf("ex[%0d]", k), {ex_v, ex_as, ex_aop, ex_br, ex_j, ex_apc, ex_f3},
          {e.v, e.asrc, e.aop, e.br, e.jmp, e.apc, e.v ? e.f3 : 3'd0});
      e = getv(k - 1);
      chk($sformatf("mem[%0d]", k - 1), {mem_v, mem_w, mem_r, mem_f3},
          {e.v, e.mw, e.mr, e.v ? e.f3 : 3'd0});
      e = getv(k - 2);
      chk($sformatf("wb[%0d]", k - 2), {wb_v, wb_rw, wb_rs, ret}, {e.v, e.rw, e.rs, e.v});
    end
    chk("table_count", cnt, 64'd9);

    // MEM_STAGES=3: single STORE
    do_reset();
    id_valid = 1'b1; id_op = 7'b0100011; id_funct3 = 3'd2;
    step(); idle();
    step(); step();
    chk("m3_mem_early", x_mem_v, 64'd0);
    step();
    chk("m3_mem_store", {x_mem_v, x_mem_w, x_mem_r, x_mem_f3}, {1'b1, 1'b1, 1'b0, 3'd2});
    step();
    chk("m3_wb_store", {x_wb_v, x_wb_rw, x_ret, x_cnt}, {1'b1, 1'b0, 1'b1, 8'd0});
    step();
    chk("m3_count", {x_ret, x_cnt}, {1'b0, 8'd1});

    // Bubble with LOAD in ID; older OP still advances
    do_reset();
    id_valid = 1'b1; id_op = 7'b0110011; step();
    id_op = 7'b0000011; bubble = 1'b1; step();
    chk("bubble_ex", {ex_v, ex_as, mem_v, mem_r}, {1'b0, 1'b0, 1'b1, 1'b0});
    idle(); step();
    chk("bubble_drain", {mem_v, mem_r, wb_v, wb_rw}, {1'b0, 1'b0, 1'b1, 1'b1});

    // Freeze (with bubble also asserted) holds everything
    do_reset();
    id_valid = 1'b1; id_op = 7'b0110011; id_funct3 = 3'd0; step();
    id_op = 7'b0100011; id_funct3 = 3'd1; step();
    id_op = 7'b0000011; id_funct3 = 3'd2; step();
    chk("pre_freeze_retire", ret, 64'd1);
    freeze = 1'b1; bubble = 1'b1;
    #1 chk("freeze_retire_now", ret, 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("freeze_ex[%0d]", c), {ex_v, ex_as, ex_aop, ex_f3}, {1'b1, 1'b1, 2'b00, 3'd2});
      chk($sformatf("freeze_mem[%0d]", c), {mem_v, mem_w, mem_r, mem_f3}, {1'b1, 1'b1, 1'b0, 3'd1});
      chk($sformatf("freeze_wb[%0d]", c), {wb_v, wb_rw, wb_rs, ret, cnt}, {1'b1, 1'b1, 2'b00, 1'b0, 32'd0});
    end
    idle(); step();
    chk("unfreeze", {ex_v, mem_v, mem_r, wb_v, wb_rw, ret, cnt},
        {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1});

    // Counter wrap on CNT_W=8
    do_reset();
    id_valid = 1'b1; id_op = 7'b0110011;
    repeat (256) step();
    idle(); repeat (6) step();
    chk("wrap_count8", x_cnt, 64'd0);
    chk("wrap_count32", cnt, 64'd256);
    id_valid = 1'b1; id_op = 7'b0110011; step();
    idle(); repeat (6) step();
    chk("wrap_plus1_8", x_cnt, 64'd1);
    chk("wrap_plus1_32", cnt, 64'd257);

    // Illegal opcode
    do_reset();
    chk("illegal_reset", ill, 64'd0);
    id_valid = 1'b1; id_op = 7'b0000000; freeze = 1'b1; step();
    chk("illegal_frozen", ill, 64'd0);
    freeze = 1'b0; step();
    chk("illegal_bubble", {ex_v, ex_as, ex_j}, 64'd0);
    chk("illegal_set", ill, 64'(TRAP));
    idle(); repeat (3) step();
    chk("illegal_wb", {wb_v, wb_rw, cnt}, 64'd0);
    chk("illegal_sticky", {ill, x_ill}, 64'({TRAP, TRAP}));

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
